// File: rtl/dmem_io_responder.sv
// dmem_io_responder: word RAM plus LED/cycle/UART-TX IO page on the core data port; UART built only with DMEM_UART_EN
module dmem_io_responder #(
    parameter int MEM_WORDS    = 1024,
    parameter int TXFIFO_DEPTH = 8,
    parameter int CLK_DIV      = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic        uart_tx,
    output logic [7:0]  leds
);
    localparam int AW = $clog2(MEM_WORDS);
    logic [31:0]   mem_q [MEM_WORDS];
    logic [7:0]    leds_q;
    logic [31:0]   cycle_q, cycle_d, status;
    logic          io, io_wr, ram_wr, unused_ok;
    logic [2:0]    sel;
    logic [AW-1:0] idx;
    assign io        = Address[22];
    assign sel       = Address[4:2];
    assign idx       = Address[2 +: AW];
    assign io_wr     = MemWrite && io;
    assign ram_wr    = MemWrite && !io;
    assign cycle_d   = (io_wr && sel == 3'd3) ? '0 : cycle_q + 32'd1;
    assign leds      = leds_q;
    assign unused_ok = ^{Address, WriteData, TXFIFO_DEPTH[0], CLK_DIV[0]};
    // RAM store; contents survive reset
    always_ff @(posedge clk)
        if (ram_wr) mem_q[idx] <= WriteData;
    // LED register and free-running cycle counter (a write clears it)
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            leds_q  <= '0;
            cycle_q <= '0;
        end else begin
            if (io_wr && sel == 3'd0) leds_q <= WriteData[7:0];
            cycle_q <= cycle_d;
        end
`ifdef DMEM_UART_EN
    localparam int FW = $clog2(TXFIFO_DEPTH);
    localparam int DW = $clog2(CLK_DIV);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t        state_q;
    logic [7:0]    fifo_q [TXFIFO_DEPTH];
    logic [FW-1:0] wr_q, rd_q;
    logic [FW:0]   cnt_q, cnt_d;
    logic [DW-1:0] div_q;
    logic [2:0]    bit_q;
    logic [7:0]    sh_q;
    logic          tx_q, ovf_q, push, push_ok, pop, full, empty, busy, tick;
    assign push    = io_wr && sel == 3'd1;
    assign full    = cnt_q == (FW+1)'(TXFIFO_DEPTH);
    assign empty   = cnt_q == '0;
    assign push_ok = push && !full;
    assign pop     = state_q == IDLE && !empty;
    assign busy    = !empty || state_q != IDLE;
    assign tick    = div_q == DW'(CLK_DIV - 1);
    assign cnt_d   = cnt_q + (FW+1)'(push_ok) - (FW+1)'(pop);
    assign status  = {28'b0, ovf_q, busy, empty, full};
    assign uart_tx = tx_q;
    // FIFO storage; stale entries are unreachable once pointers reset
    always_ff @(posedge clk)
        if (push_ok) fifo_q[wr_q] <= WriteData[7:0];
    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
            if (io_wr && sel == 3'd2) ovf_q <= 1'b0;
            else if (push && full) ovf_q <= 1'b1;
        end
    // 8N1 transmitter; tx_q is registered so the line follows the state exactly
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE:
                    if (pop) begin
                        sh_q    <= fifo_q[rd_q];
                        div_q   <= '0;
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                START:
                    if (tick) begin
                        div_q   <= '0;
                        bit_q   <= '0;
                        tx_q    <= sh_q[0];
                        state_q <= DATA;
                    end else div_q <= div_q + 1'b1;
                DATA:
                    if (tick) begin
                        div_q   <= '0;
                        sh_q    <= sh_q >> 1;
                        bit_q   <= bit_q + 1'b1;
                        tx_q    <= (bit_q == 3'd7) ? 1'b1 : sh_q[1];
                        state_q <= (bit_q == 3'd7) ? STOP : DATA;
                    end else div_q <= div_q + 1'b1;
                STOP:
                    if (tick) begin
                        div_q   <= '0;
                        state_q <= IDLE;
                    end else div_q <= div_q + 1'b1;
            endcase
        end
`else
    assign status  = '0;
    assign uart_tx = 1'b1;
`endif
    // Zero-latency read mux over RAM and the IO page
    always_comb
        ReadData = !io ? mem_q[idx] :
                   sel == 3'd0 ? {24'b0, leds_q} :
                   sel == 3'd2 ? status :
                   sel == 3'd3 ? cycle_q : '0;
endmodule
